fifo_serial_tx: RTL and testbench

Parallel-to-serial transmitter that drains words from a show-ahead FIFO read port and shifts them out LSB-first on a 1-bit valid/ready stream.
- Pairs with the serial shift-register receiver, which shifts in LSB-first.
- Sits between an output FIFO and the inter-core serial link of the NPU.
- Provides per-word first/last markers, a programmable inter-word gap and a transmitted-word counter.

---
 rtl/fifo_serial_tx.sv | 134 +++++++++++++
 tb/tb_fifo_serial_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - FIFO-fed LSB-first serial transmitter with first/last markers
// Purpose: pops words from a show-ahead FIFO and shifts them out one bit per
//   accepted handshake, with an optional idle gap after every word.
// Ports:
//   clk, reset_b          clock, asynchronous active-low reset
//   tx_en, tx_clear       pop enable, synchronous abort/clear
//   fifo_rdata, fifo_empty show-ahead FIFO head and empty flag
//   fifo_rd_enb           one-cycle pop strobe (combinational)
//   s_data/s_valid/s_ready serial bit stream with handshake
//   s_first, s_last       qualify bit 0 / bit DATA_WIDTH-1 of a word
//   busy, word_count      activity flag, completed-word counter (wraps)
module fifo_serial_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  tx_en,
  input  logic                  tx_clear,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_enb,
  output logic                  s_data,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic                  s_first,
  output logic                  s_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic                  pop;
  logic                  can_pop;

  assign can_pop = tx_en & ~fifo_empty;

  always_comb begin
    state_d      = state_q;
    shift_reg_d  = shift_reg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    word_count_d = word_count_q;
    pop          = 1'b0;
    if (tx_clear) begin
      // Abort beats everything, including a pop that would otherwise happen now.
      state_d      = ST_IDLE;
      shift_reg_d  = '0;
      bit_cnt_d    = '0;
      gap_cnt_d    = '0;
      word_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (can_pop) begin
            pop         = 1'b1;
            shift_reg_d = fifo_rdata;
            bit_cnt_d   = '0;
            state_d     = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (s_ready) begin
            shift_reg_d = {1'b0, shift_reg_q[DATA_WIDTH-1:1]};
            bit_cnt_d   = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              word_count_d = word_count_q + CNT_WIDTH'(1);
              bit_cnt_d    = '0;
              if (GAP_CYCLES > 0) begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
              end else if (can_pop) begin
                // Zero-gap mode: reload on the last-bit transfer so valid never drops.
                pop         = 1'b1;
                shift_reg_d = fifo_rdata;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          if (gap_cnt_q == LAST_GAP) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= ST_IDLE;
      shift_reg_q  <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  // The IDLE pop term is combinational from FIFO inputs, so it is masked
  // directly while reset is held to keep the FIFO untouched.
  assign fifo_rd_enb = pop & reset_b;
  assign s_valid     = (state_q == ST_SHIFT);
  assign s_data      = s_valid & shift_reg_q[0];
  assign s_first     = s_valid & (bit_cnt_q == '0);
  assign s_last      = s_valid & (bit_cnt_q == LAST_BIT);
  assign busy        = (state_q != ST_IDLE);
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - scoreboard bench for fifo_serial_tx (lane 0 gap=1, lane 1 gap=0)
module tb_fifo_serial_tx;

  logic        clk;
  logic        reset_b;
  logic        tx_en       [2];
  logic        tx_clear    [2];
  logic [15:0] fifo_rdata  [2];
  logic        fifo_empty  [2];
  logic        fifo_rd_enb [2];
  logic        s_data      [2];
  logic        s_valid     [2];
  logic        s_ready     [2];
  logic        s_first     [2];
  logic        s_last      [2];
  logic        busy        [2];
  logic [15:0] word_count  [2];

  logic [15:0] fifo_mem [2][1024];
  int          fifo_wr  [2];
  int          fifo_rd  [2];
  logic [15:0] exp_mem  [2][1024];
  int          exp_wr   [2];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int G       = (g == 0) ? 1 : 0;
    localparam int MIN_GAP = (G == 0) ? 1 : G + 2;
    logic [15:0] cur;
    int          idx, since, exp_cnt, exp_rd;
    logic        in_word, hold, b2b, pop_seen;
    logic [2:0]  hold_bits;

    fifo_serial_tx #(.DATA_WIDTH(16), .GAP_CYCLES(G), .CNT_WIDTH(16)) u_dut (
      .clk        (clk),
      .reset_b    (reset_b),
      .tx_en      (tx_en[g]),
      .tx_clear   (tx_clear[g]),
      .fifo_rdata (fifo_rdata[g]),
      .fifo_empty (fifo_empty[g]),
      .fifo_rd_enb(fifo_rd_enb[g]),
      .s_data     (s_data[g]),
      .s_valid    (s_valid[g]),
      .s_ready    (s_ready[g]),
      .s_first    (s_first[g]),
      .s_last     (s_last[g]),
      .busy       (busy[g]),
      .word_count (word_count[g])
    );

    // Monitor: a popped word is expected to appear as 16 LSB-first bits.
    always @(negedge clk) begin
      if (!reset_b) begin
        chk($sformatf("l%0d_rst_out", g), {s_valid[g], s_data[g], s_first[g], s_last[g],
            busy[g], fifo_rd_enb[g], word_count[g]}, 0);
        in_word = 0; idx = 0; exp_cnt = 0; hold = 0; b2b = 0; since = -1; pop_seen = 0;
      end else begin
        chk($sformatf("l%0d_word_count", g), word_count[g], exp_cnt[15:0]);
        if (hold) chk($sformatf("l%0d_stall_hold", g),
            {s_valid[g], s_data[g], s_first[g], s_last[g]}, {1'b1, hold_bits});
        if (b2b) chk($sformatf("l%0d_back_to_back", g), s_valid[g], 1);
        b2b = 0;
        if (since >= 0) since++;
        if (since > 0 && s_valid[g]) begin
          chk($sformatf("l%0d_gap_len", g), since >= MIN_GAP, 1);
          since = -1;
        end
        pop_seen = 0;
        hold = 0;
        if (tx_clear[g]) begin
          chk($sformatf("l%0d_clr_nopop", g), fifo_rd_enb[g], 0);
          in_word = 0; exp_cnt = 0; since = -1;
        end else begin
          if (s_valid[g] && s_ready[g]) begin
            chk($sformatf("l%0d_xfer_in_word", g), in_word, 1);
            if (in_word) begin
              chk($sformatf("l%0d_bit%0d", g, idx), {s_data[g], s_first[g], s_last[g]},
                  {cur[idx[3:0]], idx == 0, idx == 15});
              idx++;
              if (idx == 16) begin
                in_word = 0;
                exp_cnt++;
                since = 0;
                b2b = (G == 0) && tx_en[g] && !fifo_empty[g];
              end
            end
          end
          hold = s_valid[g] && !s_ready[g];
          hold_bits = {s_data[g], s_first[g], s_last[g]};
          if (fifo_rd_enb[g]) begin
            chk($sformatf("l%0d_pop_nonempty", g), fifo_empty[g], 0);
            chk($sformatf("l%0d_pop_between_words", g), in_word, 0);
            chk($sformatf("l%0d_pop_expected", g), exp_wr[g] != exp_rd, 1);
            cur = exp_mem[g][exp_rd % 1024];
            exp_rd++;
            in_word = 1;
            idx = 0;
            pop_seen = 1;
          end
        end
      end
    end
  end

  task automatic drive_fifo();
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = (fifo_wr[i] == fifo_rd[i]);
      fifo_rdata[i] = fifo_empty[i] ? 16'h0 : fifo_mem[i][fifo_rd[i] % 1024];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (g_lane[0].pop_seen) fifo_rd[0]++;
    if (g_lane[1].pop_seen) fifo_rd[1]++;
    drive_fifo();
  endtask

  task automatic push(input int i, input logic [15:0] w);
    fifo_mem[i][fifo_wr[i] % 1024] = w;
    fifo_wr[i]++;
    exp_mem[i][exp_wr[i] % 1024] = w;
    exp_wr[i]++;
    drive_fifo();
  endtask

  // Expected per-cycle trace of one word on lane 0: {pop, valid, data, first, last, busy}.
  task automatic trace(input logic [15:0] word, input int lo_a, input int lo_b,
                       input int ncyc, input string tag);
    int idx = 0;
    int done = -1;
    logic rdy, v;
    logic [5:0] e;
    push(0, word);
    for (int c = 0; c < ncyc; c++) begin
      rdy = !(c >= lo_a && c <= lo_b);
      s_ready[0] = rdy;
      v = (c >= 1) && (idx < 16);
      e = {(c == 0), v, v & word[idx[3:0]], v && (idx == 0), v && (idx == 15),
           (c >= 1) && (idx < 16 || c <= done + 1)};
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, c), {fifo_rd_enb[0], s_valid[0], s_data[0],
          s_first[0], s_last[0], busy[0]}, e);
      if (v && rdy) begin
        if (idx == 15) done = c;
        idx++;
      end
      step();
    end
    s_ready[0] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, last_c;
    logic [5:0] e3;
    reset_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_en[i] = 1'b0; tx_clear[i] = 1'b0; s_ready[i] = 1'b1;
      fifo_wr[i] = 0; fifo_rd[i] = 0; exp_wr[i] = 0;
    end
    drive_fifo();
    repeat (3) step();
    @(negedge clk);
    chk("reset_state", {s_valid[0], busy[0], fifo_rd_enb[0], word_count[0],
        s_valid[1], busy[1], fifo_rd_enb[1], word_count[1]}, 0);
    step();
    reset_b = 1'b1;
    tx_en[0] = 1'b1;
    tx_en[1] = 1'b1;

    // Empty FIFO with tx_en: nothing moves.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("t4_idle_c%0d", c), {fifo_rd_enb[0], s_valid[0], busy[0],
          fifo_rd_enb[1], s_valid[1], busy[1]}, 0);
      step();
    end
    chk("t4_count", {word_count[0], word_count[1]}, 0);

    // Single word, then the same word with a 3-cycle stall.
    trace(16'hA5C3, -1, -1, 19, "t1");
    chk("t1_count", word_count[0], 1);
    trace(16'hA5C3, 3, 5, 22, "t2");
    chk("t2_count", word_count[0], 2);

    // Zero-gap lane: two words back to back.
    push(1, 16'h0001);
    push(1, 16'h8000);
    for (int c = 0; c < 35; c++) begin
      e3 = {(c == 0 || c == 16), (c >= 1 && c <= 32), (c == 1 || c == 32),
            (c == 1 || c == 17), (c == 16 || c == 32), (c >= 1 && c <= 32)};
      @(negedge clk);
      chk($sformatf("t3_c%0d", c), {fifo_rd_enb[1], s_valid[1], s_data[1],
          s_first[1], s_last[1], busy[1]}, e3);
      step();
    end
    chk("t3_count", word_count[1], 2);

    // tx_en dropped mid-word: the word completes, no second pop.
    push(0, 16'($urandom));
    push(0, 16'($urandom));
    pops = 0;
    last_c = -1;
    for (int c = 0; c < 25; c++) begin
      if (c == 5) tx_en[0] = 1'b0;
      @(negedge clk);
      if (fifo_rd_enb[0]) pops++;
      if (s_valid[0] && s_ready[0] && s_last[0]) last_c = c;
      step();
    end
    chk("t5_pops", pops, 1);
    chk("t5_last_cycle", last_c, 16);
    chk("t5_count", word_count[0], 3);
    chk("t5_fifo_left", fifo_wr[0] - fifo_rd[0], 1);

    // Clear during bit 5 of the leftover word.
    tx_en[0] = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c == 6) tx_clear[0] = 1'b1;
      @(negedge clk);
      if (c == 6) chk("t6_before_clear", {s_valid[0], fifo_rd_enb[0], word_count[0]}, {2'b10, 16'd3});
      step();
    end
    tx_clear[0] = 1'b0;
    @(negedge clk);
    chk("t6_after_clear", {s_valid[0], busy[0], fifo_rd_enb[0], word_count[0]}, 0);
    step();

    // Clear while IDLE pop conditions hold: pop must wait one cycle.
    push(0, 16'h3C5A);
    tx_clear[0] = 1'b1;
    @(negedge clk);
    chk("t6_clear_blocks_pop", fifo_rd_enb[0], 0);
    step();
    tx_clear[0] = 1'b0;
    @(negedge clk);
    chk("t6_pop_after_clear", fifo_rd_enb[0], 1);
    repeat (6) step();

    // Asynchronous reset mid-word.
    reset_b = 1'b0;
    #1;
    chk("t6_async_reset", {s_valid[0], s_data[0], s_first[0], s_last[0], busy[0],
        fifo_rd_enb[0], word_count[0]}, 0);
    step();
    step();
    reset_b = 1'b1;

    // Randomized traffic on both lanes.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        s_ready[i]  = ($urandom_range(3) != 0);
        tx_en[i]    = ($urandom_range(15) != 0);
        tx_clear[i] = ($urandom_range(99) == 0);
        if ($urandom_range(7) == 0 && (fifo_wr[i] - fifo_rd[i]) < 8) push(i, 16'($urandom));
      end
      step();
    end

    // Drain everything still queued.
    for (int i = 0; i < 2; i++) begin
      s_ready[i] = 1'b1; tx_en[i] = 1'b1; tx_clear[i] = 1'b0;
    end
    for (int k = 0; k < 2000; k++) begin
      if (fifo_empty[0] && fifo_empty[1] && !busy[0] && !busy[1]) break;
      step();
    end
    @(negedge clk);
    chk("l0_drained", g_lane[0].exp_rd, exp_wr[0]);
    chk("l1_drained", g_lane[1].exp_rd, exp_wr[1]);
    chk("idle_after_drain", {busy[0], busy[1], fifo_empty[0], fifo_empty[1]}, 4'b0011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
